// File: rtl/ofdm_frame_sched.sv
// ofdm_frame_sched
// Replays stored 2-bit QPSK symbols from a synchronous-read buffer into the
// OFDM chain's Wishbone-style input. It sends one frame of frm_len symbols at
// a time, for n_frm frames. After each frame it waits for the chain's output
// cycle (sink_cyc) to fall, then idles for GAP cycles before the next frame.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle burst request (honoured only when idle)
//   frm_len, n_frm      symbols per frame / frames per burst (latched on start)
//   mem_addr, mem_dat   buffer read port (data returns one cycle after addr)
//   DAT_O, WE_O, STB_O, CYC_O, ACK_I   master side of the OFDM input port
//   sink_cyc            CYC of the chain's final output; falling edge = frame done
//   busy, done          not-idle flag / one-cycle end-of-burst pulse
//   frm_cnt             frames completed in the current burst
//   err                 sticky watchdog flag, cleared by an accepted start
module ofdm_frame_sched #(
  parameter int AW   = 12,
  parameter int GAP  = 30,
  parameter int TO_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] frm_len,
  input  logic [7:0]    n_frm,
  output logic [AW-1:0] mem_addr,
  input  logic [1:0]    mem_dat,
  output logic [1:0]    DAT_O,
  output logic          WE_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic          ACK_I,
  input  logic          sink_cyc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frm_cnt,
  output logic          err
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT_END, S_GAPW, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   len_q, len_d;
  logic [7:0]      nfrm_q, nfrm_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            fin_q, fin_d;
  logic            sink_q, sink_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            stb;
  logic            accept;
  logic            fall;
  logic [TO_W-1:0] wd_inc;
  logic [7:0]      cnt_inc;

  assign stb     = (state_q == S_SEND);
  assign accept  = stb & ACK_I;
  assign fall    = sink_q & ~sink_cyc;
  assign wd_inc  = wd_q + TO_W'(1);
  // frm_cnt never runs past the latched frame count.
  assign cnt_inc = (cnt_q != nfrm_q) ? cnt_q + 8'd1 : cnt_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    nfrm_d   = nfrm_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    base_d   = base_q;
    idx_d    = idx_q;
    fin_d    = fin_q;
    sink_d   = sink_cyc;
    wd_d     = wd_q;
    gap_d    = gap_q;
    mem_addr = '0;

    // A sink_cyc fall is only meaningful while a frame is in flight.
    if ((state_q == S_SEND || state_q == S_WAIT_END) && fall) fin_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = frm_len;
          nfrm_d  = n_frm;
          cnt_d   = '0;
          err_d   = 1'b0;
          base_d  = '0;
          idx_d   = '0;
          fin_d   = 1'b0;
          wd_d    = '0;
          gap_d   = '0;
          state_d = (frm_len == '0 || n_frm == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_addr = base_q;
        state_d  = S_SEND;
      end
      S_SEND: begin
        // Look one word ahead on accept so back-to-back ACKs stream 1 word/cycle;
        // with ACK low the address (and hence the returned word) holds.
        mem_addr = base_q + idx_q + {{(AW-1){1'b0}}, accept};
        if (accept) begin
          if (idx_q == len_q - AW'(1)) begin
            idx_d   = '0;
            base_d  = base_q + len_q;
            wd_d    = '0;
            state_d = S_WAIT_END;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_WAIT_END: begin
        // A fall landing on the expiry cycle wins: normal completion, no err.
        if (fin_q || fall) begin
          fin_d   = 1'b0;
          cnt_d   = cnt_inc;
          gap_d   = '0;
          state_d = S_GAPW;
        end else if (wd_inc == '1) begin
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
          gap_d   = '0;
          state_d = S_GAPW;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_GAPW: begin
        if (gap_q == GW'(GAP - 1)) begin
          gap_d   = '0;
          state_d = (cnt_q == nfrm_q) ? S_DONE : S_FETCH;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      nfrm_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      base_q  <= '0;
      idx_q   <= '0;
      fin_q   <= 1'b0;
      sink_q  <= 1'b0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nfrm_q  <= nfrm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      fin_q   <= fin_d;
      sink_q  <= sink_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign STB_O   = stb;
  assign WE_O    = stb;
  assign CYC_O   = stb;
  assign DAT_O   = stb ? mem_dat : 2'b00;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign frm_cnt = cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// Testbench for ofdm_frame_sched: a synchronous-read symbol buffer model, an
// ACK driver (steady or toggling), a sink_cyc model that pulses 5 cycles after
// each frame, and a scoreboard of expected (address, symbol) pairs per transfer.
module tb_ofdm_frame_sched;
  localparam int AW   = 12;
  localparam int GAP  = 8;
  localparam int TO_W = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] frm_len = '0;
  logic [7:0]    n_frm = '0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_dat;
  logic [1:0]    DAT_O;
  logic          WE_O, STB_O, CYC_O;
  logic          ACK_I = 1'b1;
  logic          sink_cyc = 1'b0;
  logic          busy, done;
  logic [7:0]    frm_cnt;
  logic          err;

  ofdm_frame_sched #(.AW(AW), .GAP(GAP), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frm_len(frm_len), .n_frm(n_frm),
    .mem_addr(mem_addr), .mem_dat(mem_dat), .DAT_O(DAT_O), .WE_O(WE_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I), .sink_cyc(sink_cyc),
    .busy(busy), .done(done), .frm_cnt(frm_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    dat;
  } exp_t;

  logic [1:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr;
  exp_t          q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            done_cnt = 0;
  int            stb_cycles = 0;
  int            cyc = 0;
  int            fall_cyc = 0;
  int            last_gap = 0;
  bit            stb_prev_m = 1'b0;
  bit            ack_tog = 1'b0;
  bit            sink_en = 1'b1;

  always @(posedge clk) begin
    mem_dat <= mem[mem_addr];
    rd_addr <= mem_addr;
    cyc     <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  // ACK driver
  initial forever begin
    @(posedge clk); #1;
    ACK_I = ack_tog ? ~ACK_I : 1'b1;
  end

  // Sink model: after strobes fall, hold sink_cyc high for 5 cycles then drop.
  initial begin
    bit sd_prev;
    int sink_left;
    sd_prev = 1'b0;
    sink_left = 0;
    forever begin
      @(posedge clk); #1;
      if (sink_en && sd_prev && STB_O === 1'b0) sink_left = 5;
      sd_prev = (STB_O === 1'b1);
      if (sink_left > 0) begin
        sink_cyc = 1'b1;
        sink_left--;
      end else begin
        sink_cyc = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    chk("strobe_tie", {30'd0, WE_O, CYC_O}, {30'd0, STB_O, STB_O});
    if (done === 1'b1) done_cnt++;
    if (STB_O === 1'b1) stb_cycles++;
    if (STB_O === 1'b1 && ACK_I) begin
      if (q.size() == 0) begin
        chk("extra_word", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rd_addr", {20'd0, rd_addr}, {20'd0, e.addr});
        chk("dat_o", {30'd0, DAT_O}, {30'd0, e.dat});
      end
    end else if (STB_O === 1'b1 && !ACK_I && q.size() > 0) begin
      chk("hold_dat", {30'd0, DAT_O}, {30'd0, q[0].dat});
      chk("hold_addr", {20'd0, mem_addr}, {20'd0, q[0].addr});
    end else if (STB_O === 1'b0) begin
      chk("idle_dat", {30'd0, DAT_O}, 32'd0);
    end
    if (STB_O === 1'b1 && !stb_prev_m) last_gap = cyc - fall_cyc;
    if (STB_O === 1'b0 && stb_prev_m) fall_cyc = cyc;
    stb_prev_m = (STB_O === 1'b1);
  end

  task automatic do_start(input int len, input int n, input bit push);
    if (push)
      for (int k = 0; k < n; k++)
        for (int j = 0; j < len; j++) begin
          exp_t e;
          e.addr = AW'((k * len + j) % (1 << AW));
          e.dat  = mem[e.addr];
          q.push_back(e);
        end
    @(posedge clk); #1;
    frm_len = AW'(len);
    n_frm   = 8'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int i;
    i = 0;
    while (done_cnt == base && i < budget) begin
      @(posedge clk);
      i++;
    end
    repeat (4) @(posedge clk);
    chk("done_once", done_cnt - base, 32'd1);
    chk("sb_empty", q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, s0, i;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 2'((a * 5 + (a >> 3)) & 3);
    mem[0] = 2'd3; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_stb", {31'd0, STB_O}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_frm_cnt", {24'd0, frm_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: four words 3,1,2,0 under continuous ACK
    d0 = done_cnt;
    do_start(4, 1, 1'b1);
    wait_done(d0, 300);
    chk("t1_frm_cnt", {24'd0, frm_cnt}, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);

    // 2: same frame with ACK toggling; data/address must hold while ACK low
    ack_tog = 1'b1;
    d0 = done_cnt;
    s0 = stb_cycles;
    do_start(4, 1, 1'b1);
    wait_done(d0, 300);
    ack_tog = 1'b0;
    chk("t2_stb_cycles_ge7", {31'd0, (stb_cycles - s0) >= 7}, 32'd1);
    chk("t2_frm_cnt", {24'd0, frm_cnt}, 32'd1);

    // 3: three 288-word frames, mid-burst start ignored
    d0 = done_cnt;
    do_start(288, 3, 1'b1);
    repeat (100) @(posedge clk);
    do_start(5, 1, 1'b0);
    wait_done(d0, 3000);
    chk("t3_frm_cnt", {24'd0, frm_cnt}, 32'd3);
    chk("t3_err", {31'd0, err}, 32'd0);

    // 4: sink never falls -> watchdog after 15 WAIT_END cycles, burst continues
    sink_en = 1'b0;
    d0 = done_cnt;
    do_start(2, 2, 1'b1);
    wait_done(d0, 400);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_frm_cnt", {24'd0, frm_cnt}, 32'd2);
    chk("t4_fall_to_rise", last_gap, 32'(GAP + 16));
    sink_en = 1'b1;
    d0 = done_cnt;
    do_start(1, 1, 1'b1);
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    wait_done(d0, 300);

    // 5: zero length / zero frames go straight to DONE
    d0 = done_cnt;
    s0 = stb_cycles;
    do_start(0, 3, 1'b1);
    @(negedge clk);
    chk("t5a_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("t5a_done_drop", {31'd0, done}, 32'd0);
    chk("t5a_busy_drop", {31'd0, busy}, 32'd0);
    do_start(5, 0, 1'b1);
    @(negedge clk);
    chk("t5b_done", {31'd0, done}, 32'd1);
    repeat (3) @(posedge clk);
    chk("t5_done_pulses", done_cnt - d0, 32'd2);
    chk("t5_no_strobes", stb_cycles - s0, 32'd0);

    // 6: reset during SEND of frame 2, then replay from address 0
    do_start(6, 3, 1'b1);
    i = 0;
    while (!(frm_cnt == 8'd1 && STB_O === 1'b1) && i < 500) begin
      @(posedge clk);
      i++;
    end
    chk("t6_reach_frame2", {31'd0, i < 500}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    chk("t6_stb", {31'd0, STB_O}, 32'd0);
    chk("t6_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_frm_cnt", {24'd0, frm_cnt}, 32'd0);
    chk("t6_dat", {30'd0, DAT_O}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt;
    do_start(4, 1, 1'b1);
    wait_done(d0, 300);
    chk("t6_frm_cnt_after", {24'd0, frm_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
